// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the multicycle MIPS-subset control path and ALUControl.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_TRAP      = 4'd15
    } state_t;

    function automatic logic is_mem_state(input state_t s);
        return s inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// mem_wait_watchdog: counts not-ready cycles in a memory state, saturating at WAIT_LIMIT.
module mem_wait_watchdog
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_mem_ready,
    output logic o_timeout
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    logic [WAIT_W-1:0] r_count;
    logic              w_at_limit;

    assign w_at_limit = r_count == LIMIT;
    // a ready in the limit cycle completes the access instead of trapping
    assign o_timeout  = i_enable && !i_mem_ready && w_at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && !i_mem_ready && !w_at_limit)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM sequencing the shared ALU, memory, IR, PC and register file.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_timeout,
    output logic [3:0] state
);

    state_t r_state, w_next;
    logic   r_illegal, r_bus;
    logic   w_timeout, w_set_illegal, w_set_timeout;

    assign state       = r_state;
    assign illegal_op  = r_illegal;
    assign bus_timeout = r_bus;

    // any state change clears the counter, so each memory state starts from zero
    mem_wait_watchdog #(
        .WAIT_LIMIT(WAIT_LIMIT),
        .WAIT_W    (WAIT_W)
    ) u_wdog (
        .clk        (clock),
        .rst_n      (reset_n),
        .i_clear    (w_next != r_state),
        .i_enable   (is_mem_state(r_state)),
        .i_mem_ready(mem_ready),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_RESET;
            r_illegal <= 1'b0;
            r_bus     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_bus <= 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default: begin
                        w_next        = S_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_IMM;
                w_next        = opcode == OP_LW ? S_MEM_READ : opcode == OP_SW ? S_MEM_WRITE : S_TRAP;
                w_set_illegal = opcode != OP_LW && opcode != OP_SW;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                w_next   = mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
                w_next     = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: w_next = S_TRAP;
            default: begin
                w_next        = S_TRAP;
                w_set_illegal = 1'b1;
            end
        endcase
        if (w_timeout) begin
            w_next        = S_TRAP;
            w_set_timeout = 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction streams with memory waits against an instruction-level model.
module tb_multicycle_control;

    localparam int LIM = 4;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done;
    logic       illegal_op, bus_timeout;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    multicycle_control #(.WAIT_LIMIT(LIM), .WAIT_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .bus_timeout(bus_timeout), .state(state)
    );

    always #5 clock = ~clock;

    int   n_cmp = 0, n_bad = 0, cyc = 0, done_at = -1;
    logic exp_ill = 1'b0, exp_bus = 1'b0;
    logic [5:0] ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done}
    wire [16:0] ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                        pc_source, instr_done};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] exp_ctrl(input int s, input logic r);
        case (s)
            1:  return {r, 3'b001, 1'b0, r, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
            2:  return {9'b000000000, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
            3:  return {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
            4:  return {9'b001100000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            5:  return {9'b000000101, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
            6:  return {9'b001010000, 1'b0, 2'b00, 2'b00, 2'b00, r};
            7:  return {9'b000000000, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
            8:  return {9'b000000011, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
            9:  return {9'b010000000, 1'b1, 2'b00, 2'b01, 2'b01, 1'b1};
            10: return {9'b100000000, 1'b0, 2'b00, 2'b00, 2'b10, 1'b1};
            11: return {9'b000000000, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
            12: return {9'b000000001, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
            default: return '0;
        endcase
    endfunction

    function automatic int lat_of(input logic [5:0] op);
        case (op)
            OP_LW:          return 5;
            OP_BEQ, OP_J:   return 3;
            default:        return 4;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input int es, input logic rdy, input logic [5:0] op);
        opcode    = op;
        mem_ready = rdy;
        @(negedge clock);
        chk("state", 32'(state), 32'(es));
        chk("ctrl", 32'(ctrl), 32'(exp_ctrl(es, rdy)));
        chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
        chk("bus_timeout", 32'(bus_timeout), 32'(exp_bus));
        if (instr_done) done_at = cyc;
        cyc++;
        @(posedge clock);
        #1;
    endtask

    // wf/wm: not-ready cycles before the fetch / data access completes
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        int start;
        start   = cyc;
        done_at = -1;
        for (int i = 0; i <= wf; i++) step(1, i == wf, op);
        step(2, rnd(), op);
        case (op)
            OP_R:    begin step(7, rnd(), op); step(8, rnd(), op); end
            OP_LW:   begin
                step(3, rnd(), op);
                for (int i = 0; i <= wm; i++) step(4, i == wm, op);
                step(5, rnd(), op);
            end
            OP_SW:   begin
                step(3, rnd(), op);
                for (int i = 0; i <= wm; i++) step(6, i == wm, op);
            end
            OP_BEQ:  step(9, rnd(), op);
            OP_J:    step(10, rnd(), op);
            default: begin step(11, rnd(), op); step(12, rnd(), op); end
        endcase
        chk("latency", 32'(done_at - start + 1), 32'(lat_of(op) + wf + wm));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        exp_ill = 1'b0;
        exp_bus = 1'b0;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_ctrl", 32'(ctrl), 32'd0);
        chk("async_rst_flags", 32'({illegal_op, bus_timeout}), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(0, rnd(), OP_R);
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(0, 1'b1, OP_R);
        foreach (ops[k]) run_instr(ops[k], 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, LIM, LIM);
        run_instr(OP_LW, LIM, LIM);
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, LIM),
                      (op == OP_LW || op == OP_SW) ? $urandom_range(0, LIM) : 0);
        end
        step(1, 1'b1, 6'b111111);
        step(2, rnd(), 6'b111111);
        exp_ill = 1'b1;
        repeat (20) step(15, rnd(), 6'b111111);
        do_reset();
        repeat (LIM + 1) step(1, 1'b0, OP_R);
        exp_bus = 1'b1;
        repeat (5) step(15, rnd(), OP_R);
        do_reset();
        step(1, 1'b1, OP_LW);
        step(2, 1'b1, OP_LW);
        step(3, 1'b1, OP_LW);
        repeat (LIM + 1) step(4, 1'b0, OP_LW);
        exp_bus = 1'b1;
        step(15, 1'b1, OP_LW);
        do_reset();
        step(1, 1'b1, OP_LW);
        #2;
        do_reset();
        run_instr(OP_BEQ, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
